sail_mem_write_sequencer: RTL and testbench

Serialises multi-byte memory write requests from several requesters into a single byte-wide memory write port. It arbitrates between requesters, captures one request at a time, and emits its bytes highest-address-first. This matches the byte order the emulator write path uses when building its write list. It sits between the generated Sail write-memory call sites and the byte-granular memory backend (DPI byte writer or on-chip store).

---
 rtl/sail_mem_write_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sail_mem_write_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sail_mem_write_sequencer.sv
// Arbitrates multi-byte write requests and drains each one highest-address-first
// onto a byte-wide memory port. Define SAIL_MEM_SEQ_RR_EN for round-robin, else fixed priority.
module sail_mem_write_sequencer #(
    parameter  int NREQ      = 2,
    parameter  int MAX_BYTES = 8,
    parameter  int ADDR_W    = 64,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1),
    localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*ADDR_W-1:0]    req_addr,
    input  logic [NREQ*CNT_W-1:0]     req_nbytes,
    input  logic [NREQ*MAX_BYTES*8-1:0] req_data,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [7:0]                mem_data,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id
);

    localparam int DATA_W = MAX_BYTES * 8;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;

    logic [ID_W-1:0]     grant;
    logic                any_valid;
    logic [ADDR_W-1:0]   addr_g;
    logic [DATA_W-1:0]   data_g;
    logic [CNT_W-1:0]    nbytes_g;

`ifdef SAIL_MEM_SEQ_RR_EN
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]     rot;
    int                  sum;

    // Rotate so bit 0 is the pointer position; the first set bit wins.
    always_comb begin
        rot   = NREQ'({req_valid, req_valid} >> ptr_q);
        grant = '0;
        sum   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = int'(ptr_q) + k;
                if (sum >= NREQ) sum = sum - NREQ;
                grant = ID_W'(sum);
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) grant = ID_W'(k);
        end
    end
`endif

    always_comb begin
        any_valid = |req_valid;
        req_ready = '0;
        if (state_q == S_IDLE && !rst && any_valid) req_ready[grant] = 1'b1;
    end

    always_comb begin
        addr_g   = '0;
        data_g   = '0;
        nbytes_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant) begin
                addr_g   = req_addr[i*ADDR_W +: ADDR_W];
                data_g   = req_data[i*DATA_W +: DATA_W];
                nbytes_g = req_nbytes[i*CNT_W +: CNT_W];
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef SAIL_MEM_SEQ_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    addr_d  = addr_g;
                    data_d  = data_g;
                    id_d    = grant;
                    cnt_d   = (nbytes_g > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : nbytes_g;
                    state_d = (cnt_d == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ready) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SAIL_MEM_SEQ_RR_EN
                ptr_d   = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next-state values so they line up with the state.
        mem_valid_d = (state_d == S_DRAIN);
        mem_addr_d  = mem_valid_d ? addr_d + ADDR_W'(cnt_d - CNT_W'(1)) : '0;
        mem_data_d  = mem_valid_d ? 8'(data_d >> {cnt_d - CNT_W'(1), 3'b000}) : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        done_id_d   = done_d ? id_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
`ifdef SAIL_MEM_SEQ_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
`ifdef SAIL_MEM_SEQ_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // NOTE: the captured payload is only read after a fresh capture, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_sail_mem_write_sequencer.sv
// Bench for sail_mem_write_sequencer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based transaction model.
module tb_sail_mem_write_sequencer;

    localparam int NREQ = 2;
    localparam int MB   = 8;
    localparam int AW   = 64;
    localparam int CW   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*CW-1:0] req_nbytes = '0;
    logic [NREQ*64-1:0] req_data = '0;
    logic               mem_valid;
    logic               mem_ready = 1'b0;
    logic [AW-1:0]      mem_addr;
    logic [7:0]         mem_data;
    logic               busy;
    logic               done;
    logic [0:0]         done_id;

    sail_mem_write_sequencer #(.NREQ(NREQ), .MAX_BYTES(MB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_nbytes(req_nbytes), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; logic [7:0] data; } byte_t;

    int total = 0;
    int bad   = 0;

    // Transaction model: pending bytes of the active request, in emission order.
    byte_t       exp_q[$];
    bit          m_active = 0;
    int          m_id = 0;
    int          m_ptr = 0;

    logic [63:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          done_ids[$];
    int          cyc = 0, t_acc = 0, t_done = 0, hold_1002 = 0, stall_cnt = 0;
    int          mr_mode = 0;
    bit          auto_clear = 1, rand_gen = 0;
    bit [NREQ-1:0] accepted = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
`ifdef SAIL_MEM_SEQ_RR_EN
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    task automatic set_req(input int i, input logic [63:0] a, input int n, input logic [63:0] d);
        req_addr[i*AW +: AW]   = a;
        req_nbytes[i*CW +: CW] = CW'(n);
        req_data[i*64 +: 64]   = d;
        req_valid[i]           = 1'b1;
    endtask

    task automatic new_req(input int i);
        logic [63:0] a;
        a = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
        set_req(i, a, $urandom_range(0, 15), {$urandom, $urandom});
    endtask

    // One clock: advance the model across the coming edge, then check the outputs after it.
    task automatic cycle();
        int g, n;
        logic [63:0] a, d;
        logic [NREQ-1:0] er;
        byte_t e;
        #1;
        cyc++;
        g  = pick(req_valid, m_ptr);
        er = '0;
        if (!rst && !m_active && (|req_valid)) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        if (mem_valid && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
        if (rst) begin
            m_active = 0;
            m_ptr    = 0;
            exp_q.delete();
        end else if (!m_active) begin
            if (|req_valid) begin
                n = int'(req_nbytes[g*CW +: CW]);
                if (n > MB) n = MB;
                a = req_addr[g*AW +: AW];
                d = req_data[g*64 +: 64];
                for (int k = n - 1; k >= 0; k--) begin
                    e.addr = a + 64'(k);
                    e.data = d[8*k +: 8];
                    exp_q.push_back(e);
                end
                m_active    = 1;
                m_id        = g;
                accepted[g] = 1'b1;
                t_acc       = cyc - 1;
            end
        end else if (exp_q.size() > 0) begin
            if (mem_ready) void'(exp_q.pop_front());
        end else begin
            m_active = 0;
            m_ptr    = (m_id + 1) % NREQ;
        end

        @(negedge clk);
        check("mem_valid", 64'(mem_valid), 64'(m_active && exp_q.size() > 0));
        check("busy", 64'(busy), 64'(m_active));
        check("done", 64'(done), 64'(m_active && exp_q.size() == 0));
        if (m_active && exp_q.size() > 0) begin
            check("mem_addr", mem_addr, exp_q[0].addr);
            check("mem_data", 64'(mem_data), 64'(exp_q[0].data));
        end
        if (m_active && exp_q.size() == 0) check("done_id", 64'(done_id), 64'(m_id));
        if (done) begin
            done_ids.push_back(int'(done_id));
            t_done = cyc;
        end
        if (mem_valid && mem_addr == 64'h1002) hold_1002++;

        for (int i = 0; i < NREQ; i++) begin
            if (accepted[i] && auto_clear) req_valid[i] = 1'b0;
            accepted[i] = 1'b0;
            if (rand_gen) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) new_req(i);
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end
        end
        case (mr_mode)
            1: mem_ready = ($urandom_range(0, 3) != 0);
            2: begin
                mem_ready = 1'b1;
                if (m_active && exp_q.size() == 3 && stall_cnt < 3) begin
                    mem_ready = 1'b0;
                    stall_cnt++;
                end
            end
            default: mem_ready = 1'b1;
        endcase
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        while ((m_active || (|req_valid)) && b < budget) begin
            cycle();
            b++;
        end
        check("drained_in_budget", 64'(b < budget), 64'd1);
    endtask

    int base, dbase;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: requests presented during reset must not be acknowledged.
        set_req(0, 64'h10, 1, 64'h1);
        set_req(1, 64'h20, 1, 64'h2);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("ready_in_reset", 64'(req_ready), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_done_id", 64'(done_id), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_data", 64'(mem_data), 64'd0);
        req_valid = '0;
        rst       = 1'b0;
        mem_ready = 1'b1;
        cycle();

        // Single 4-byte write.
        base = log_addr.size();
        dbase = done_ids.size();
        set_req(0, 64'h1000, 4, 64'hDDCC_BBAA);
        wait_idle(50);
        check("t1_addr0", log_addr[base],   64'h1003);
        check("t1_data0", 64'(log_data[base]),   64'hDD);
        check("t1_addr3", log_addr[base+3], 64'h1000);
        check("t1_data3", 64'(log_data[base+3]), 64'hAA);
        check("t1_ndone", 64'(done_ids.size() - dbase), 64'd1);
        check("t1_done_lat", 64'(t_done - t_acc), 64'd5);

        // Backpressure on the second byte.
        mr_mode = 2; stall_cnt = 0; hold_1002 = 0;
        base = log_addr.size();
        dbase = done_ids.size();
        set_req(0, 64'h1000, 4, 64'hDDCC_BBAA);
        wait_idle(50);
        check("bp_hold", 64'(hold_1002), 64'd4);
        check("bp_data1", 64'(log_data[base+1]), 64'hCC);
        check("bp_nbytes", 64'(log_addr.size() - base), 64'd4);
        check("bp_ndone", 64'(done_ids.size() - dbase), 64'd1);
        mr_mode = 0;

        // Zero-length then overflow-length requests.
        base = log_addr.size();
        set_req(1, 64'h4000, 0, 64'h0);
        wait_idle(20);
        check("zero_nbytes", 64'(log_addr.size() - base), 64'd0);
        check("zero_done_lat", 64'(t_done - t_acc), 64'd1);
        set_req(0, 64'h5000, 15, 64'h0807_0605_0403_0201);
        wait_idle(50);
        check("ovf_nbytes", 64'(log_addr.size() - base), 64'd8);
        check("ovf_first", log_addr[base], 64'h5007);
        check("ovf_last", log_addr[base+7], 64'h5000);
        check("ovf_last_data", 64'(log_data[base+7]), 64'h01);

        // Address wrap at the top of the address space.
        base = log_addr.size();
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFE, 4, 64'h4433_2211);
        wait_idle(50);
        check("wrap_a0", log_addr[base],   64'h1);
        check("wrap_a1", log_addr[base+1], 64'h0);
        check("wrap_a2", log_addr[base+2], 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_a3", log_addr[base+3], 64'hFFFF_FFFF_FFFF_FFFE);

        // Two requesters holding valid continuously.
        auto_clear = 0;
        dbase = done_ids.size();
        set_req(0, 64'h100, 1, 64'hA0);
        set_req(1, 64'h200, 1, 64'hB1);
        repeat (13) cycle();
        req_valid = '0;
        auto_clear = 1;
        wait_idle(20);
        check("arb_ndone", 64'(done_ids.size() - dbase >= 4), 64'd1);
        for (int k = 0; k < 4; k++) begin
`ifdef SAIL_MEM_SEQ_RR_EN
            check("arb_id", 64'(done_ids[dbase+k]), 64'(k % 2));
`else
            check("arb_id", 64'(done_ids[dbase+k]), 64'd0);
`endif
        end

        // Reset in the middle of an 8-byte drain.
        base = log_addr.size();
        set_req(0, 64'h2000, 8, 64'h8877_6655_4433_2211);
        for (int b = 0; b < 30 && log_addr.size() < base + 2; b++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        dbase = done_ids.size();
        repeat (10) cycle();
        check("mid_rst_no_done", 64'(done_ids.size() - dbase), 64'd0);
        set_req(1, 64'h3000, 2, 64'hBEEF);
        wait_idle(20);
        check("post_rst_a0", log_addr[log_addr.size()-2], 64'h3001);
        check("post_rst_d0", 64'(log_data[log_data.size()-2]), 64'hBE);
        check("post_rst_id", 64'(done_ids[done_ids.size()-1]), 64'd1);

        // Randomized traffic with random backpressure and occasional resets.
        mr_mode = 1; rand_gen = 1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        rand_gen = 0; mr_mode = 0;
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
